// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM codes, branch encodings,
// control-bundle struct and the hazard-detection helpers.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned STATE_W         = 2;
  localparam int unsigned TMR_W           = 8;
  localparam int unsigned REG_W           = 5;
  localparam int unsigned BR_W            = 2;
  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W_DEF       = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_t;

  localparam logic [BR_W-1:0] BR_NONE = 2'b00;
  localparam logic [BR_W-1:0] BR_BEQ  = 2'b01;
  localparam logic [BR_W-1:0] BR_BNE  = 2'b10;
  localparam logic [BR_W-1:0] BR_JMP  = 2'b11;

  typedef struct packed {
    logic mem_req;
    logic pc_write;
    logic pc_src;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pipe_hold;
  } ctrl_t;

  // Free-running pipeline: fetch and IF/ID advance, nothing squashed or held.
  localparam ctrl_t CTRL_IDLE = '{
    mem_req: 1'b0, pc_write: 1'b1, pc_src: 1'b0, ifid_write: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, pipe_hold: 1'b0
  };

  function automatic logic branch_taken(input logic [BR_W-1:0] br, input logic zero);
    logic taken;
    taken = 1'b0;
    unique case (br)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = !zero;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // $0 is hardwired, so a load into it never creates a dependency.
  function automatic logic load_use(input logic             mem_read,
                                    input logic [REG_W-1:0] ex_rt,
                                    input logic [REG_W-1:0] id_rs,
                                    input logic [REG_W-1:0] id_rt,
                                    input logic             uses_rt);
    return mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_timer.sv
// Memory wait-state timer: load to 1, increment, clear, terminal-count flag.
module mem_wait_timer
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  input  logic clear,
  output logic tc
);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TMR_W'(1);
    end else if (inc) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign tc = (cnt == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, MEM-resolved branch
// flushes, data-memory wait states with timeout, and a saturating stall counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_UsesRt,
  input  logic             IDEX_MemRead,
  input  logic [REG_W-1:0] IDEX_Rt,
  input  logic [BR_W-1:0]  EXMEM_Branch,
  input  logic             EXMEM_Zero,
  input  logic             EXMEM_MemRW,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic             PipeHold,
  output logic             BusErr,
  output logic [CNT_W-1:0] StallCount
);

  state_t     state, state_nxt;
  ctrl_t      ctrl, ctrl_out;
  logic       take, lu, resolve;
  logic       tmr_load, tmr_inc, tmr_clear, tmr_tc;
  logic       err_set;
  logic       bus_err;
  logic [CNT_W-1:0] stall_cnt;

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .inc   (tmr_inc),
    .clear (tmr_clear),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      bus_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (err_set) begin
        bus_err <= 1'b1;
      end
      if (!ctrl.pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Next state and control decode; hold cases first, hazard resolution last.
  always_comb begin
    ctrl      = CTRL_IDLE;
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_inc   = 1'b0;
    tmr_clear = 1'b0;
    err_set   = 1'b0;
    resolve   = 1'b0;
    take      = branch_taken(EXMEM_Branch, EXMEM_Zero);
    lu        = load_use(IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt);

    unique case (state)
      ST_RUN: begin
        ctrl.mem_req = EXMEM_MemRW;
        if (EXMEM_MemRW && !MemReady) begin
          ctrl.pipe_hold  = 1'b1;
          ctrl.pc_write   = 1'b0;
          ctrl.ifid_write = 1'b0;
          state_nxt       = ST_MEM_WAIT;
          tmr_load        = 1'b1;
        end else begin
          resolve = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        ctrl.mem_req = 1'b1;
        if (MemReady) begin
          resolve   = 1'b1;
          state_nxt = ST_RUN;
          tmr_clear = 1'b1;
        end else begin
          ctrl.pipe_hold  = 1'b1;
          ctrl.pc_write   = 1'b0;
          ctrl.ifid_write = 1'b0;
          if (tmr_tc) begin
            state_nxt = ST_ERR;
            err_set   = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end
      ST_ERR: begin
        ctrl.mem_req    = 1'b0;
        ctrl.pipe_hold  = 1'b1;
        ctrl.pc_write   = 1'b0;
        ctrl.ifid_write = 1'b0;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    // A taken branch squashes the ID instruction, so its load-use hazard is moot.
    if (resolve) begin
      if (take) begin
        ctrl.pc_src      = 1'b1;
        ctrl.pc_write    = 1'b1;
        ctrl.ifid_flush  = 1'b1;
        ctrl.idex_flush  = 1'b1;
        ctrl.exmem_flush = 1'b1;
      end else if (lu) begin
        ctrl.pc_write   = 1'b0;
        ctrl.ifid_write = 1'b0;
        ctrl.idex_flush = 1'b1;
      end
    end
  end

  // Outputs are forced to their reset values while rst_n is low.
  assign ctrl_out   = rst_n ? ctrl : CTRL_IDLE;
  assign MemReq     = ctrl_out.mem_req;
  assign PCWrite    = ctrl_out.pc_write;
  assign PCSrc      = ctrl_out.pc_src;
  assign IFIDWrite  = ctrl_out.ifid_write;
  assign IFIDFlush  = ctrl_out.ifid_flush;
  assign IDEXFlush  = ctrl_out.idex_flush;
  assign EXMEMFlush = ctrl_out.exmem_flush;
  assign PipeHold   = ctrl_out.pipe_hold;
  assign BusErr     = bus_err;
  assign StallCount = stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: per-cycle expected outputs are queued as
// stimulus is applied and compared at the falling edge.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  IFID_Rs, IFID_Rt, IDEX_Rt;
  logic        IFID_UsesRt, IDEX_MemRead, EXMEM_Zero, EXMEM_MemRW, MemReady;
  logic [1:0]  EXMEM_Branch;
  logic        MemReq, PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, PipeHold, BusErr;
  logic [15:0] StallCount;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero), .EXMEM_MemRW(EXMEM_MemRW),
    .MemReady(MemReady), .MemReq(MemReq), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .EXMEMFlush(EXMEMFlush), .PipeHold(PipeHold), .BusErr(BusErr), .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: MemReq PCWrite PCSrc IFIDWrite IFIDFlush IDEXFlush EXMEMFlush PipeHold BusErr
  localparam logic [8:0] F_NORM   = 9'b0_1_0_1_0_0_0_0_0;
  localparam logic [8:0] F_NORM_M = 9'b1_1_0_1_0_0_0_0_0;
  localparam logic [8:0] F_LU     = 9'b0_0_0_0_0_1_0_0_0;
  localparam logic [8:0] F_LU_M   = 9'b1_0_0_0_0_1_0_0_0;
  localparam logic [8:0] F_TAKE   = 9'b0_1_1_1_1_1_1_0_0;
  localparam logic [8:0] F_TAKE_M = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] F_HOLD   = 9'b1_0_0_0_0_0_0_1_0;
  localparam logic [8:0] F_ERR    = 9'b0_0_0_0_0_0_0_1_1;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       mrd;
    logic [4:0] irt;
    logic [1:0] br;
    logic       z;
    logic       rw;
    logic       rdy;
  } stim_t;

  typedef struct packed {
    stim_t      s;
    logic [8:0] f;
  } step_t;

  logic [24:0] sb[$];
  logic [15:0] exp_cnt;
  int          checks;
  int          failures;

  function automatic step_t mk(input int rs, input int rt, input bit ur, input bit mrd, input int irt,
                               input int br, input bit z, input bit rw, input bit rdy,
                               input logic [8:0] f);
    step_t st;
    st.s.rs  = 5'(rs);
    st.s.rt  = 5'(rt);
    st.s.ur  = ur;
    st.s.mrd = mrd;
    st.s.irt = 5'(irt);
    st.s.br  = 2'(br);
    st.s.z   = z;
    st.s.rw  = rw;
    st.s.rdy = rdy;
    st.f     = f;
    return st;
  endfunction

  function automatic logic [24:0] observed();
    return {MemReq, PCWrite, PCSrc, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, PipeHold, BusErr, StallCount};
  endfunction

  task automatic apply(input stim_t s);
    IFID_Rs      = s.rs;
    IFID_Rt      = s.rt;
    IFID_UsesRt  = s.ur;
    IDEX_MemRead = s.mrd;
    IDEX_Rt      = s.irt;
    EXMEM_Branch = s.br;
    EXMEM_Zero   = s.z;
    EXMEM_MemRW  = s.rw;
    MemReady     = s.rdy;
  endtask

  task automatic test_reset();
    logic [24:0] exp;
    step_t busy;
    busy = mk(8, 8, 1, 1, 8, 1, 1, 1, 0, F_NORM);
    rst_n = 1'b0;
    apply(busy.s);
    #3;
    sb.push_back({F_NORM, 16'd0});
    exp = sb.pop_front();
    checks++;
    if (observed() !== exp) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", observed(), exp);
    end
    @(negedge clk);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, F_NORM).s);
    rst_n   = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_load_use();
    step_t steps[$];
    logic [24:0] exp;
    steps.push_back(mk(8, 3, 0, 1, 8, 0, 0, 0, 0, F_LU));
    steps.push_back(mk(8, 3, 0, 0, 8, 0, 0, 0, 0, F_NORM));
    steps.push_back(mk(4, 9, 1, 1, 9, 0, 0, 0, 0, F_LU));
    steps.push_back(mk(4, 9, 1, 0, 0, 0, 0, 0, 0, F_NORM));
    steps.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, F_NORM));
    steps.push_back(mk(3, 9, 0, 1, 9, 0, 0, 0, 0, F_NORM));
    steps.push_back(mk(3, 7, 1, 0, 3, 0, 0, 0, 0, F_NORM));
    foreach (steps[i]) begin
      @(posedge clk); #1;
      apply(steps[i].s);
      sb.push_back({steps[i].f, exp_cnt});
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL load_use[%0d] got=%h exp=%h", i, observed(), exp);
      end
      if (!exp[23] && exp_cnt != 16'hffff) exp_cnt++;
    end
  endtask

  task automatic test_branch();
    step_t steps[$];
    logic [24:0] exp;
    steps.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, F_TAKE));
    steps.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, F_NORM));
    steps.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0, F_NORM));
    steps.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0, F_TAKE));
    steps.push_back(mk(0, 0, 0, 0, 0, 3, 0, 0, 0, F_TAKE));
    steps.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, F_TAKE));
    steps.push_back(mk(8, 0, 0, 1, 8, 1, 1, 0, 0, F_TAKE));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, F_NORM));
    foreach (steps[i]) begin
      @(posedge clk); #1;
      apply(steps[i].s);
      sb.push_back({steps[i].f, exp_cnt});
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL branch[%0d] got=%h exp=%h", i, observed(), exp);
      end
      if (!exp[23] && exp_cnt != 16'hffff) exp_cnt++;
    end
  endtask

  task automatic test_mem_wait();
    step_t steps[$];
    logic [24:0] exp;
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, F_NORM_M));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, F_HOLD));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, F_HOLD));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, F_HOLD));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, F_NORM_M));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, F_NORM));
    steps.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 0, F_HOLD));
    steps.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 1, F_TAKE_M));
    steps.push_back(mk(8, 0, 0, 1, 8, 0, 0, 1, 0, F_HOLD));
    steps.push_back(mk(8, 0, 0, 1, 8, 0, 0, 1, 1, F_LU_M));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, F_NORM));
    foreach (steps[i]) begin
      @(posedge clk); #1;
      apply(steps[i].s);
      sb.push_back({steps[i].f, exp_cnt});
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL mem_wait[%0d] got=%h exp=%h", i, observed(), exp);
      end
      if (!exp[23] && exp_cnt != 16'hffff) exp_cnt++;
    end
  endtask

  task automatic test_timeout();
    step_t steps[$];
    logic [24:0] exp;
    for (int k = 0; k < 16; k++) steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, F_HOLD));
    steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, F_ERR));
    steps.push_back(mk(0, 0, 0, 0, 0, 3, 0, 1, 1, F_ERR));
    steps.push_back(mk(8, 0, 0, 1, 8, 0, 0, 0, 1, F_ERR));
    foreach (steps[i]) begin
      @(posedge clk); #1;
      apply(steps[i].s);
      sb.push_back({steps[i].f, exp_cnt});
      @(negedge clk);
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL timeout[%0d] got=%h exp=%h", i, observed(), exp);
      end
      if (!exp[23] && exp_cnt != 16'hffff) exp_cnt++;
    end
  endtask

  // Enters from ERR (left by test_timeout), resets, then repeats from MEM_WAIT.
  task automatic test_reset_midop();
    step_t steps[$];
    logic [24:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      @(posedge clk); #2;
      apply(mk(8, 8, 1, 1, 8, 3, 0, 1, 0, F_NORM).s);
      rst_n = 1'b0;
      #1;
      sb.push_back({F_NORM, 16'd0});
      exp = sb.pop_front();
      checks++;
      if (observed() !== exp) begin
        failures++;
        $display("FAIL async_reset[%0d] got=%h exp=%h", pass, observed(), exp);
      end
      exp_cnt = 16'd0;
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, F_NORM).s);
      #1;
      rst_n = 1'b1;
      steps.delete();
      steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, F_NORM));
      steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, F_NORM_M));
      if (pass == 0) begin
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, F_HOLD));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, F_HOLD));
      end
      foreach (steps[i]) begin
        @(posedge clk); #1;
        apply(steps[i].s);
        sb.push_back({steps[i].f, exp_cnt});
        @(negedge clk);
        exp = sb.pop_front();
        checks++;
        if (observed() !== exp) begin
          failures++;
          $display("FAIL reset_resume[%0d.%0d] got=%h exp=%h", pass, i, observed(), exp);
        end
        if (!exp[23] && exp_cnt != 16'hffff) exp_cnt++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 16'd0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_midop();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
